uart_frame_tx: RTL and testbench
================================

// Module: uart_frame_tx
// PURPOSE
//  Buffered, parametrised UART transmitter that streams pipeline results (e.g. disparity/depth bytes)
//  off-board via the top-level uart_txd pin. Accepts bytes over valid/ready into an internal FIFO.
//  On bytes flagged start-of-frame, inserts a 16-bit sync header so the host can re-align.
//  Adds configurable parity and stop bits.
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency
//  BAUD        115_200      line rate; BAUD_DIV = (CLK_HZ + BAUD/2) / BAUD, must be >= 2
//  FIFO_DEPTH  16           byte-buffer entries; power of two, >= 2
//  PARITY      0            0 none, 1 even, 2 odd
//  STOP_BITS   1            1 or 2
//  SYNC_WORD   16'hA55A     header sent MSB byte first before each SOF byte
// PORTS
//  clk_in          in   1                      system clock
//  rst_in          in   1                      synchronous active-high reset
//  data_in         in   8                      payload byte
//  sof_in          in   1                      data_in is first byte of a frame (sampled with valid_in)
//  valid_in        in   1                      data_in/sof_in valid
//  ready_out       out  1                      FIFO can accept; transfer on valid_in && ready_out
//  uart_txd        out  1                      serial line, idle high
//  busy_out        out  1                      serializer active or FIFO non-empty
//  fifo_count_out  out  $clog2(FIFO_DEPTH+1)   bytes held in FIFO (excludes byte in serializer)
// BEHAVIOUR
//  Reset: uart_txd=1, ready_out=1, busy_out=0, fifo_count_out=0; FIFO emptied; FSM->IDLE; baud/bit counters 0.
//  FIFO: entries {sof,byte}. ready_out = (count != FIFO_DEPTH) from registered count; push and pop in the same
//   cycle leave count unchanged. Push into an empty FIFO is not poppable until the next cycle.
//  Frame on line: start(0), data[0]..data[7] LSB first, parity bit if PARITY!=0 (even: ^data; odd: ~^data),
//   then STOP_BITS ones. NBITS = 10 + (PARITY!=0) + (STOP_BITS-1). Every bit lasts exactly BAUD_DIV cycles.
//  FSM: IDLE -> (FIFO non-empty) LOAD. LOAD pops the head.
//   If sof=1: load SYNC_WORD[15:8] -> SEND_HI -> SYNC_WORD[7:0] -> SEND_LO -> held byte -> SEND_BYTE.
//   If sof=0: load byte -> SEND_BYTE.
//   Held byte is latched at pop; the FIFO is not re-read for the header.
//  Serializer: on load, uart_txd drives the start bit from the next cycle.
//   A bit counter advances every BAUD_DIV cycles; the byte ends after NBITS*BAUD_DIV cycles.
//   If another byte is pending (header remainder, or FIFO non-empty), its start bit follows the last stop bit
//   with zero idle cycles. Otherwise FSM -> IDLE with uart_txd=1.
//  Latency: valid_in accepted at cycle t into an idle, empty block -> start bit on uart_txd at t+2.
//  busy_out = (state != IDLE) || (count != 0); drops the cycle after the final stop bit completes.
//  Order: bytes leave in acceptance order. sof only ever prepends a header; no payload is dropped or duplicated.
//  Full: valid_in held with ready_out=0 has no effect; no overflow possible.
//  Reset mid-byte: line forced high on the next cycle (host sees a framing error). FIFO contents discarded.
//   The next accepted byte is sent cleanly from a full start bit.
//  Counters saturate never: baud counter wraps at BAUD_DIV-1, bit counter clears at NBITS-1.
// STRUCTURE
//  uart_pkg: parity_t enum (PAR_NONE/PAR_EVEN/PAR_ODD), tx_state_t enum (IDLE, LOAD, SEND_HI, SEND_LO, SEND_BYTE),
//   function baud_div(clk_hz, baud), localparam DEFAULT_SYNC = 16'hA55A.
//  Sub-module: sync_fifo #(WIDTH=9, DEPTH=FIFO_DEPTH) (clk_in, rst_in, push, pop, din, dout, count, full, empty),
//   read-first, registered count.
//  Top: FSM + serializer (shift register, baud counter, bit counter, parity).
// TESTING (bench uses CLK_HZ=100, BAUD=10 -> BAUD_DIV=10)
//  1 Assert rst_in 2 cycles -> uart_txd=1, ready_out=1, busy_out=0, fifo_count_out=0 throughout and after.
//  2 PARITY=0, push 0x35 sof=0 -> line 0,1,0,1,0,1,1,0,0,1 (start, LSB-first data, stop), 10 cycles each;
//    busy_out low exactly 100 cycles after start bit.
//  3 Push 0x00 sof=1 -> bytes 0xA5, 0x5A, 0x00 decoded back-to-back with no idle cycles; 300 cycles total.
//  4 Push 20 bytes 0x00..0x13 with valid_in held -> ready_out drops once fifo_count_out=16 (17 accepted);
//    resumes as bytes drain; all 20 decoded in order.
//  5 0x07 with PARITY=1 -> parity bit 1; PARITY=2 -> 0; STOP_BITS=2 -> stop high 20 cycles, next start after.
//  6 rst_in during data bit 3 with 5 bytes queued -> uart_txd=1 next cycle, fifo_count_out=0;
//    then push 0x81 -> one clean frame decodes 0x81.

Source files
------------

// File: rtl/uart_frame_tx_pkg.sv
// Shared types and helpers for the framed UART transmitter.
package uart_frame_tx_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        SEND_HI   = 3'd2,
        SEND_LO   = 3'd3,
        SEND_BYTE = 3'd4
    } tx_state_t;

    localparam logic [15:0] DEFAULT_SYNC = 16'hA55A;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic logic parity_bit(input logic [7:0] d, input parity_t mode);
        case (mode)
            PAR_EVEN: return ^d;
            PAR_ODD:  return ~^d;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Byte-stream valid/ready handshake feeding the transmitter.
interface uart_frame_tx_if;
    logic [7:0] data_in;
    logic       sof_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output sof_in, output valid_in, input ready_out);
    modport slave  (input data_in, input sof_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_frame_tx_sync_fifo.sv
// Read-first synchronous FIFO with a registered occupancy count.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write port; contents are don't-care until the count covers them.
    always_ff @(posedge clk_in) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Buffered UART transmitter; start-of-frame bytes are preceded by a 16-bit sync header.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int          CLK_HZ     = 100_000_000,
    parameter int          BAUD       = 115_200,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PARITY     = 0,
    parameter int          STOP_BITS  = 1,
    parameter logic [15:0] SYNC_WORD  = DEFAULT_SYNC
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    uart_frame_tx_if.slave                    bus,
    output logic                              uart_txd,
    output logic                              busy_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_out
);

    localparam int      BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam parity_t PAR_MODE = parity_t'(PARITY[1:0]);
    localparam int      NBITS    = 10 + ((PARITY != 0) ? 1 : 0) + (STOP_BITS - 1);
    localparam int      BW       = $clog2(BAUD_DIV);
    localparam int      NW       = $clog2(NBITS);
    localparam int      CW       = $clog2(FIFO_DEPTH + 1);

    tx_state_t         state_r;
    logic [NBITS-1:0]  shift_r;
    logic [BW-1:0]     baud_cnt_r;
    logic [NW-1:0]     bit_cnt_r;
    logic              txd_r;
    logic [7:0]        held_r;

    logic [8:0]        fifo_dout_s;
    logic [CW-1:0]     fifo_count_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic              push_s;
    logic              pop_s;
    logic              load_s;
    logic              baud_end_s;
    logic              frame_end_s;
    logic [NBITS-1:0]  load_frame_s;
    tx_state_t         load_state_s;

    // Whole line frame, bit 0 first: start, data LSB first, optional parity, stop bits.
    function automatic logic [NBITS-1:0] build_frame(input logic [7:0] d);
        logic [NBITS-1:0] f;
        f      = {NBITS{1'b1}};
        f[0]   = 1'b0;
        f[8:1] = d;
        if (PAR_MODE != PAR_NONE) begin
            f[9] = parity_bit(d, PAR_MODE);
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (push_s),
        .pop    (pop_s),
        .din    ({bus.sof_in, bus.data_in}),
        .dout   (fifo_dout_s),
        .count  (fifo_count_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign push_s         = bus.valid_in && !fifo_full_s;
    assign bus.ready_out  = !fifo_full_s;
    assign fifo_count_out = fifo_count_s;
    assign busy_out       = (state_r != IDLE) || !fifo_empty_s;
    assign uart_txd       = txd_r;

    assign baud_end_s  = (baud_cnt_r == BW'(BAUD_DIV - 1));
    assign frame_end_s = baud_end_s && (bit_cnt_r == NW'(NBITS - 1));

    // A new frame is chained directly onto the last stop bit so no idle gap appears.
    assign pop_s  = (state_r == LOAD) ||
                    ((state_r == SEND_BYTE) && frame_end_s && !fifo_empty_s);
    assign load_s = pop_s ||
                    (((state_r == SEND_HI) || (state_r == SEND_LO)) && frame_end_s);

    // Selects the next frame: header remainder, held payload, or the FIFO head.
    always_comb begin
        load_frame_s = build_frame(fifo_dout_s[7:0]);
        load_state_s = SEND_BYTE;
        case (state_r)
            SEND_HI: begin
                load_frame_s = build_frame(SYNC_WORD[7:0]);
                load_state_s = SEND_LO;
            end
            SEND_LO: begin
                load_frame_s = build_frame(held_r);
                load_state_s = SEND_BYTE;
            end
            default: begin
                if (fifo_dout_s[8]) begin
                    load_frame_s = build_frame(SYNC_WORD[15:8]);
                    load_state_s = SEND_HI;
                end else begin
                    load_frame_s = build_frame(fifo_dout_s[7:0]);
                    load_state_s = SEND_BYTE;
                end
            end
        endcase
    end

    // Sequencer and serializer: state, shift register, baud and bit counters, line register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r    <= IDLE;
            shift_r    <= {NBITS{1'b1}};
            baud_cnt_r <= {BW{1'b0}};
            bit_cnt_r  <= {NW{1'b0}};
            txd_r      <= 1'b1;
            held_r     <= 8'h00;
        end else if (load_s) begin
            txd_r      <= load_frame_s[0];
            shift_r    <= {1'b1, load_frame_s[NBITS-1:1]};
            baud_cnt_r <= {BW{1'b0}};
            bit_cnt_r  <= {NW{1'b0}};
            state_r    <= load_state_s;
            if (pop_s) begin
                held_r <= fifo_dout_s[7:0];
            end
        end else begin
            case (state_r)
                IDLE: begin
                    txd_r <= 1'b1;
                    if (!fifo_empty_s) begin
                        state_r <= LOAD;
                    end
                end
                SEND_HI, SEND_LO, SEND_BYTE: begin
                    if (frame_end_s) begin
                        state_r    <= IDLE;
                        txd_r      <= 1'b1;
                        baud_cnt_r <= {BW{1'b0}};
                        bit_cnt_r  <= {NW{1'b0}};
                    end else if (baud_end_s) begin
                        baud_cnt_r <= {BW{1'b0}};
                        bit_cnt_r  <= bit_cnt_r + NW'(1);
                        txd_r      <= shift_r[0];
                        shift_r    <= {1'b1, shift_r[NBITS-1:1]};
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    txd_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench: three transmitter configurations, each with a line decoder checking queued expectations.
module tb_uart_frame_tx;

    localparam int PAR_A [3] = '{0, 1, 2};
    localparam int STP_A [3] = '{1, 2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_s = 8'h00;
    logic       sof_s = 1'b0;
    logic [2:0] valid_v = 3'b000;
    wire  [2:0] txd_w;
    wire  [2:0] busy_w;
    wire  [4:0] cnt0;
    wire  [4:0] cnt1;
    wire  [4:0] cnt2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_gen = 0;
    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_frame_tx_if bus0 ();
    uart_frame_tx_if bus1 ();
    uart_frame_tx_if bus2 ();
    assign bus0.data_in = data_s; assign bus0.sof_in = sof_s; assign bus0.valid_in = valid_v[0];
    assign bus1.data_in = data_s; assign bus1.sof_in = sof_s; assign bus1.valid_in = valid_v[1];
    assign bus2.data_in = data_s; assign bus2.sof_in = sof_s; assign bus2.valid_in = valid_v[2];

    uart_frame_tx #(.CLK_HZ(100), .BAUD(10), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1),
                    .SYNC_WORD(16'hA55A)) dut0 (
        .clk_in(clk), .rst_in(rst), .bus(bus0), .uart_txd(txd_w[0]),
        .busy_out(busy_w[0]), .fifo_count_out(cnt0));
    uart_frame_tx #(.CLK_HZ(100), .BAUD(10), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(2),
                    .SYNC_WORD(16'hA55A)) dut1 (
        .clk_in(clk), .rst_in(rst), .bus(bus1), .uart_txd(txd_w[1]),
        .busy_out(busy_w[1]), .fifo_count_out(cnt1));
    uart_frame_tx #(.CLK_HZ(100), .BAUD(10), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1),
                    .SYNC_WORD(16'hA55A)) dut2 (
        .clk_in(clk), .rst_in(rst), .bus(bus2), .uart_txd(txd_w[2]),
        .busy_out(busy_w[2]), .fifo_count_out(cnt2));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic ready_of(input int id);
        case (id)
            0:       return bus0.ready_out;
            1:       return bus1.ready_out;
            default: return bus2.ready_out;
        endcase
    endfunction

    function automatic void exp_push(input int id, input logic [8:0] e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [8:0] exp_pop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Line decoder: samples each bit mid-period; a reset during a frame discards it.
    task automatic mon(input int id);
        int par, stp, nb, t0, last_end, rgen;
        logic [11:0] bits;
        logic [8:0] e;
        logic ok;
        par = PAR_A[id];
        stp = STP_A[id];
        nb = 10 + ((par != 0) ? 1 : 0) + (stp - 1);
        last_end = -1000;
        forever begin
            @(negedge clk);
            if (!rst && txd_w[id] == 1'b0) begin
                t0 = cyc;
                rgen = rst_gen;
                bits = 12'hFFF;
                for (int k = 1; k < 10 * nb; k++) begin
                    @(negedge clk);
                    if (k % 10 == 5) bits[k / 10] = txd_w[id];
                end
                if (rgen == rst_gen) begin
                    if (q_size(id) == 0) begin
                        check($sformatf("dut%0d_unexpected_frame", id), int'(bits[8:1]), -1);
                    end else begin
                        e = exp_pop(id);
                        check($sformatf("dut%0d_byte", id), int'(bits[8:1]), int'(e[7:0]));
                        ok = (bits[0] == 1'b0) && (bits[nb - 1] == 1'b1);
                        if (stp == 2) ok = ok && (bits[nb - 2] == 1'b1);
                        if (par == 1) ok = ok && (bits[9] == ^e[7:0]);
                        if (par == 2) ok = ok && (bits[9] == ~^e[7:0]);
                        check($sformatf("dut%0d_framing", id), int'(ok), 1);
                        if (e[8]) check($sformatf("dut%0d_idle_gap", id), t0 - last_end, 0);
                    end
                end
                last_end = t0 + 10 * nb;
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    // Offers one byte; b2b marks bytes expected to follow the previous frame with no gap.
    task automatic push_b(input int id, input logic [7:0] d, input logic sof, input logic b2b);
        int n;
        @(negedge clk);
        data_s = d;
        sof_s = sof;
        valid_v[id] = 1'b1;
        n = 0;
        while (!ready_of(id) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", int'(ready_of(id)), 1);
        if (sof) begin
            exp_push(id, {b2b, 8'hA5});
            exp_push(id, {1'b1, 8'h5A});
            exp_push(id, {1'b1, d});
        end else begin
            exp_push(id, {b2b, d});
        end
        @(negedge clk);
        valid_v[id] = 1'b0;
        sof_s = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy_w != 3'b000 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", int'(n < limit), 1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n, acc, t_start;
        logic drop_seen;

        // Reset held for two cycles.
        @(negedge clk);
        check("rst_txd", int'(txd_w[0]), 1);
        check("rst_ready", int'(bus0.ready_out), 1);
        check("rst_busy", int'(busy_w), 0);
        check("rst_count", int'(cnt0), 0);
        @(negedge clk);
        check("rst2_txd", int'(txd_w), 7);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_txd", int'(txd_w[0]), 1);
        check("post_rst_count", int'(cnt0), 0);
        check("post_rst_busy", int'(busy_w), 0);

        // Single byte: latency and busy duration.
        @(negedge clk);
        data_s = 8'h35;
        sof_s = 1'b0;
        valid_v[0] = 1'b1;
        exp_push(0, {1'b0, 8'h35});
        @(negedge clk);
        valid_v[0] = 1'b0;
        check("lat_t0_line", int'(txd_w[0]), 1);
        check("lat_t0_count", int'(cnt0), 1);
        @(negedge clk);
        check("lat_t1_line", int'(txd_w[0]), 1);
        @(negedge clk);
        check("lat_t2_start", int'(txd_w[0]), 0);
        n = 0;
        while (busy_w[0] && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("busy_len_single", n, 100);
        wait_idle(100);

        // Start-of-frame byte gets the sync header.
        push_b(0, 8'h00, 1'b1, 1'b0);
        n = 0;
        while (txd_w[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("hdr_start_seen", int'(txd_w[0]), 0);
        n = 0;
        while (busy_w[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("busy_len_header", n, 300);
        wait_idle(100);

        // Streaming into a full FIFO.
        acc = 0;
        drop_seen = 1'b0;
        n = 0;
        while (acc < 20 && n < 5000) begin
            @(negedge clk);
            n++;
            if (!bus0.ready_out && !drop_seen) begin
                drop_seen = 1'b1;
                check("full_accepted", acc, 17);
                check("full_count", int'(cnt0), 16);
            end
            data_s = 8'(acc);
            valid_v[0] = 1'b1;
            if (bus0.ready_out) begin
                exp_push(0, {(acc != 0), 8'(acc)});
                acc++;
            end
        end
        @(negedge clk);
        valid_v[0] = 1'b0;
        check("stream_all_accepted", acc, 20);
        check("ready_dropped", int'(drop_seen), 1);
        wait_idle(3000);

        // Parity and stop-bit variants.
        push_b(1, 8'h07, 1'b0, 1'b0);
        push_b(1, 8'h07, 1'b0, 1'b1);
        push_b(2, 8'h07, 1'b0, 1'b0);
        wait_idle(1000);

        // Reset in the middle of a byte with five more queued.
        push_b(0, 8'h10, 1'b0, 1'b0);
        n = 0;
        while (txd_w[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        t_start = cyc;
        for (int i = 1; i < 6; i++) push_b(0, 8'(8'h10 + i), 1'b0, 1'b1);
        n = 0;
        while (cyc < t_start + 44 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_queued", int'(cnt0), 5);
        check("pre_rst_line_low", int'(txd_w[0]), 0);
        rst = 1'b1;
        rst_gen++;
        q0.delete();
        @(negedge clk);
        check("mid_rst_line_high", int'(txd_w[0]), 1);
        check("mid_rst_count", int'(cnt0), 0);
        check("mid_rst_busy", int'(busy_w[0]), 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        push_b(0, 8'h81, 1'b0, 1'b0);
        wait_idle(500);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
